// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and byte width.
// PROG_LOADER_CHECKSUM_EN adds the CHK state used for the trailing checksum byte.
package program_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_WRITE = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: collects the low byte, then forms the instruction word from the
// high byte. Flags any set bit in the high byte that does not fit the word width.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter int prog_mem_width = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lo_load_i,
  input  logic                      hi_load_i,
  input  logic [BYTE_W-1:0]         byte_i,
  output logic [prog_mem_width-1:0] word_o,
  output logic                      unused_err_o
);

  localparam int HI_W = prog_mem_width - BYTE_W;
  localparam logic [BYTE_W-1:0] HI_MASK = BYTE_W'((1 << HI_W) - 1);

  logic [BYTE_W-1:0]         lo_q;
  logic [prog_mem_width-1:0] word_q;

  // Low byte latch; only meaningful once the high byte arrives, so no reset.
  always_ff @(posedge clk) begin
    if (lo_load_i) lo_q <= byte_i;
  end

  // Completed word; doubles as the memory write-data register, hence reset to 0.
  always_ff @(posedge clk) begin
    if (rst)            word_q <= '0;
    else if (hi_load_i) word_q <= {byte_i[HI_W-1:0], lo_q};
  end

  assign word_o       = word_q;
  assign unused_err_o = |(byte_i & ~HI_MASK);

endmodule

// File: rtl/program_loader.sv
// program_loader: streams bytes (low byte first) into program memory words and
// holds the CPU in reset (busy) while loading. With PROG_LOADER_CHECKSUM_EN
// defined, a trailing byte is checked against the XOR of all data bytes.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int prog_mem_length = 8,
  parameter int prog_mem_width  = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [prog_mem_length:0]   len,
  input  logic                       in_valid,
  input  logic [BYTE_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       mem_we,
  output logic [prog_mem_length-1:0] mem_addr,
  output logic [prog_mem_width-1:0]  mem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam logic [prog_mem_length:0] LEN_MAX = {1'b1, {prog_mem_length{1'b0}}};
  localparam logic [prog_mem_length:0] CNT_ONE = {{prog_mem_length{1'b0}}, 1'b1};

  state_e                       state_q, state_d;
  logic [prog_mem_length:0]     cnt_q, cnt_inc, len_q;
  logic [prog_mem_length-1:0]   mem_addr_q;
  logic                         in_ready_q, mem_we_q, busy_q, done_q, err_q, err_d;
  logic                         xfer, len_ok, last_word, unused_err;
  logic                         lo_load, hi_load;

  assign xfer      = in_valid & in_ready_q;
  assign len_ok    = (len != '0) && (len <= LEN_MAX);
  assign cnt_inc   = cnt_q + CNT_ONE;
  assign last_word = (cnt_inc >= len_q);
  assign lo_load   = xfer && (state_q == S_LO);
  assign hi_load   = xfer && (state_q == S_HI);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_q;

  // Running XOR of data bytes, restarted by every accepted start.
  always_ff @(posedge clk) begin
    if (rst)                                       chk_q <= '0;
    else if (state_q == S_IDLE && start && len_ok) chk_q <= '0;
    else if (lo_load || hi_load)                   chk_q <= chk_q ^ in_data;
  end
`endif

  word_assembler #(
    .prog_mem_width(prog_mem_width)
  ) u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .lo_load_i    (lo_load),
    .hi_load_i    (hi_load),
    .byte_i       (in_data),
    .word_o       (mem_wdata),
    .unused_err_o (unused_err)
  );

  // Next-state and next-error decode; stalls simply keep the current state.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = S_LO;
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_LO:    if (xfer) state_d = S_HI;
      S_HI: begin
        if (xfer) begin
          state_d = S_WRITE;
          if (unused_err) err_d = 1'b1;
        end
      end
      S_WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        state_d = last_word ? S_CHK : S_LO;
`else
        state_d = last_word ? S_FIN : S_LO;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = S_FIN;
          if (in_data != chk_q) err_d = 1'b1;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      mem_addr_q <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      busy_q   <= (state_d != S_IDLE);
      mem_we_q <= (state_d == S_WRITE);
      done_q   <= (state_d == S_FIN) && !err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      in_ready_q <= (state_d == S_LO) || (state_d == S_HI) || (state_d == S_CHK);
`else
      in_ready_q <= (state_d == S_LO) || (state_d == S_HI);
`endif
      if (state_q == S_IDLE && state_d == S_LO) begin
        cnt_q <= '0;
        len_q <= len;
      end
      if (hi_load)             mem_addr_q <= cnt_q[prog_mem_length-1:0];
      if (state_q == S_WRITE)  cnt_q      <= cnt_inc;
    end
  end

  assign in_ready = in_ready_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = err_q;

endmodule
